// File: rtl/alu_pkg.sv
// Opcode and flag-bit definitions shared by the ALU, its decoder and the result stage.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBB = 5'd3;
    localparam logic [4:0] OP_MUL  = 5'd4;
    localparam logic [4:0] OP_FADD = 5'd5;
    localparam logic [4:0] OP_FSUB = 5'd6;
    localparam logic [4:0] OP_FMUL = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NAND = 5'd11;
    localparam logic [4:0] OP_NOR  = 5'd12;
    localparam logic [4:0] OP_XNOR = 5'd13;
    localparam logic [4:0] OP_NOT  = 5'd14;
    localparam logic [4:0] OP_NEG  = 5'd15;

    localparam logic [4:0] OP_LAST_LEGAL = 5'd15;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_legal_op(input logic [4:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// In-order FIFO with extra-MSB pointers; storage is not reset, read data reads 0 while empty.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO refuses the push even when the head leaves in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: updates the Z/N/C/V flag register and queues results toward writeback.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [31:0]       in_result,
    input  logic              in_carry,
    input  logic              in_ovf,
    input  logic [REG_AW-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [REG_AW-1:0] out_dest,
    output logic [3:0]        out_flags,
    output logic [3:0]        flags,
    output logic              err_opcode
);

    localparam int EW = 32 + REG_AW + 4;

    logic [3:0]    flags_q;
    logic [3:0]    flags_next;
    logic          err_q;
    logic          full;
    logic          empty;
    logic          accept;
    logic          legal;
    logic          zr;
    logic          nr;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign legal    = is_legal_op(in_opcode);
    assign zr       = (in_result == 32'd0);
    assign nr       = in_result[31];

    always_comb begin
        flags_next = flags_q;
        case (in_opcode)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
                flags_next[FLAG_Z] = zr;
                flags_next[FLAG_N] = nr;
                flags_next[FLAG_C] = in_carry;
                flags_next[FLAG_V] = in_ovf;
            end
            OP_MUL: begin
                flags_next[FLAG_Z] = zr;
                flags_next[FLAG_N] = nr;
                flags_next[FLAG_C] = 1'b0;
                flags_next[FLAG_V] = 1'b0;
            end
            // Float results: sign bit ignored for zero so +0 and -0 both set Z.
            OP_FADD, OP_FSUB, OP_FMUL: begin
                flags_next[FLAG_Z] = (in_result[30:0] == 31'd0);
                flags_next[FLAG_N] = nr;
            end
            OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT: begin
                flags_next[FLAG_Z] = zr;
                flags_next[FLAG_N] = nr;
            end
            OP_NEG: begin
                flags_next[FLAG_Z] = zr;
                flags_next[FLAG_N] = nr;
                flags_next[FLAG_C] = !zr;
                flags_next[FLAG_V] = (in_result == 32'h8000_0000);
            end
            default: flags_next = flags_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (legal) flags_q <= flags_next;
            else       err_q   <= 1'b1;
        end
    end

    assign wdata = {in_result, in_dest, flags_next};

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && legal),
        .wdata (wdata),
        .pop   (out_ready),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign out_valid  = !empty;
    assign out_result = rdata[EW-1 -: 32];
    assign out_dest   = rdata[4 +: REG_AW];
    assign out_flags  = rdata[3:0];
    assign flags      = flags_q;
    assign err_opcode = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expected values.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [31:0] in_result;
    logic        in_carry;
    logic        in_ovf;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_dest;
    logic [3:0]  out_flags;
    logic [3:0]  flags;
    logic        err_opcode;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.DEPTH(2), .REG_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_ovf     (in_ovf),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .out_flags  (out_flags),
        .flags      (flags),
        .err_opcode (err_opcode)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] res,
                         input logic c, input logic o, input logic [3:0] d);
        in_valid  = v;
        in_opcode = op;
        in_result = res;
        in_carry  = c;
        in_ovf    = o;
        in_dest   = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_err", {31'd0, err_opcode}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);

        // Fill the FIFO, then reset asynchronously between edges.
        drive(1'b1, 5'd0, 32'd1, 1'b0, 1'b0, 4'd1);
        tick();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd2);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_flags", {28'd0, flags}, 32'h6);
        chk("full_head", out_result, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_flags", {28'd0, flags}, 32'd0);
        chk("arst_err", {31'd0, err_opcode}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

        // ADD, zero result with carry.
        out_ready = 1'b1;
        drive(1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 4'd3);
        tick();
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out_dest", {28'd0, out_dest}, 32'd3);
        chk("add_out_flags", {28'd0, out_flags}, 32'hA);
        chk("add_flags", {28'd0, flags}, 32'hA);

        // NEG of most-negative value; pushed while the ADD pops.
        drive(1'b1, 5'd15, 32'h8000_0000, 1'b0, 1'b0, 4'd5);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        chk("neg_out_result", out_result, 32'h8000_0000);
        chk("neg_out_dest", {28'd0, out_dest}, 32'd5);
        chk("neg_out_flags", {28'd0, out_flags}, 32'h7);
        chk("neg_flags", {28'd0, flags}, 32'h7);
        tick();
        chk("neg_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure with three back-to-back pushes.
        out_ready = 1'b0;
        drive(1'b1, 5'd9, 32'h11, 1'b0, 1'b0, 4'd1);
        tick();
        drive(1'b1, 5'd10, 32'h22, 1'b0, 1'b0, 4'd2);
        tick();
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_flags_logic", {28'd0, flags}, 32'h3);
        drive(1'b1, 5'd4, 32'h33, 1'b1, 1'b1, 4'd4);
        tick();
        chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_result", out_result, 32'h11);
        chk("bp_hold_dest", {28'd0, out_dest}, 32'd1);
        chk("bp_third_not_taken", {28'd0, flags}, 32'h3);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_result", out_result, 32'h22);
        chk("bp_pop1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        chk("bp_third_result", out_result, 32'h33);
        chk("bp_third_dest", {28'd0, out_dest}, 32'd4);
        chk("bp_third_flags", {28'd0, out_flags}, 32'h0);
        chk("bp_third_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Illegal opcode: consumed, nothing queued, flags frozen.
        drive(1'b1, 5'd20, 32'd0, 1'b1, 1'b1, 4'd7);
        tick();
        chk("ill_err", {31'd0, err_opcode}, 32'd1);
        chk("ill_no_entry", {31'd0, out_valid}, 32'd0);
        chk("ill_flags", {28'd0, flags}, 32'h0);
        chk("ill_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 5'd0, 32'd7, 1'b0, 1'b0, 4'd6);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        chk("ill_next_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_next_result", out_result, 32'd7);
        chk("ill_err_sticky", {31'd0, err_opcode}, 32'd1);
        tick();

        // C/V retention across logic ops, then float negative zero.
        drive(1'b1, 5'd2, 32'h10, 1'b1, 1'b1, 4'd8);
        tick();
        chk("sub_flags", {28'd0, flags}, 32'h3);
        drive(1'b1, 5'd8, 32'd5, 1'b0, 1'b0, 4'd9);
        tick();
        chk("and_flags", {28'd0, flags}, 32'h3);
        drive(1'b1, 5'd5, 32'h8000_0000, 1'b0, 1'b0, 4'd10);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        chk("fadd_flags", {28'd0, flags}, 32'hF);
        chk("fadd_out_flags", {28'd0, out_flags}, 32'hF);
        chk("fadd_out_dest", {28'd0, out_dest}, 32'd10);
        tick();
        chk("final_drained", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
